// File: rtl/alu_operand_stage.sv
// -----------------------------------------------------------------------------
// alu_operand_stage
//
// Decode-to-execute pipeline stage sitting directly in front of the ALU.
// Takes decoded RV32I integer instructions (OP, OP-IMM, LUI, AUIPC), turns
// the opcode/funct fields into an ALU operation, picks operand 1/operand 2 and
// registers the result behind a valid/ready handshake. A second (skid)
// register lets the stage keep a registered o_ready without dropping the beat
// that arrives in the cycle downstream stalls. The ALU hangs combinationally
// off the outputs.
//
// Optional feature: define ALU_OPSTAGE_BYPASS_EN to add a forwarding port
// that replaces rs1/rs2 read data with in-flight result data at accept time.
//
// Ports
//   i_clk, i_rst_n      clock (rising edge), asynchronous active-low reset
//   i_flush             synchronous flush; empties the stage, drops input beat
//   i_valid / o_ready   upstream handshake (o_ready is a flop output)
//   i_opcode, i_funct3, i_funct7_5   instruction fields
//   i_rs1_data, i_rs2_data, i_imm, i_pc, i_rd   operand sources / destination
//   o_valid / i_ready   downstream handshake
//   o_op1, o_op2, o_alu_op, o_rd, o_wb_en, o_illegal   registered beat
//   Bypass build only:
//   i_byp_valid, i_byp_rd, i_byp_data   forwarded result
//   i_rs1, i_rs2                        source register indices
// -----------------------------------------------------------------------------

package alu_operand_stage_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_opcode_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

endpackage

module alu_operand_stage
   import alu_operand_stage_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_flush,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [6:0]        i_opcode,
   input  logic [2:0]        i_funct3,
   input  logic              i_funct7_5,
   input  logic [XLEN-1:0]   i_rs1_data,
   input  logic [XLEN-1:0]   i_rs2_data,
   input  logic [XLEN-1:0]   i_imm,
   input  logic [XLEN-1:0]   i_pc,
   input  logic [REG_AW-1:0] i_rd,
`ifdef ALU_OPSTAGE_BYPASS_EN
   input  logic              i_byp_valid,
   input  logic [REG_AW-1:0] i_byp_rd,
   input  logic [XLEN-1:0]   i_byp_data,
   input  logic [REG_AW-1:0] i_rs1,
   input  logic [REG_AW-1:0] i_rs2,
`endif
   output logic              o_valid,
   input  logic              i_ready,
   output logic [XLEN-1:0]   o_op1,
   output logic [XLEN-1:0]   o_op2,
   output alu_opcode_t       o_alu_op,
   output logic [REG_AW-1:0] o_rd,
   output logic              o_wb_en,
   output logic              o_illegal
);

   // One fully decoded beat, as held in either the output or skid register.
   typedef struct packed {
      logic [XLEN-1:0]   op1;
      logic [XLEN-1:0]   op2;
      alu_opcode_t       alu_op;
      logic [REG_AW-1:0] rd;
      logic              wb_en;
      logic              illegal;
   } beat_t;

   localparam beat_t BEAT_RESET = '{
      op1:     '0,
      op2:     '0,
      alu_op:  ALU_ADD,
      rd:      '0,
      wb_en:   1'b0,
      illegal: 1'b0
   };

   // Shared funct3 map for OP and OP-IMM. funct7_5 selects SUB only for
   // register-register adds (in OP-IMM that bit is immediate data), but it
   // selects SRA for both forms.
   function automatic alu_opcode_t funct_map(input logic [2:0] funct3,
                                             input logic       funct7_5,
                                             input logic       is_reg);
      alu_opcode_t op;
      case (funct3)
         3'b000:  op = (is_reg && funct7_5) ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = funct7_5 ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   // -------------------------------------------------------------------------
   // Source operand selection (with optional forwarding)
   // -------------------------------------------------------------------------
   logic [XLEN-1:0] src_raw  [2];
   logic [XLEN-1:0] src_data [2];

   assign src_raw[0] = i_rs1_data;
   assign src_raw[1] = i_rs2_data;

`ifdef ALU_OPSTAGE_BYPASS_EN
   logic [REG_AW-1:0] src_idx [2];

   assign src_idx[0] = i_rs1;
   assign src_idx[1] = i_rs2;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
`ifdef ALU_OPSTAGE_BYPASS_EN
         // x0 is hard-wired zero, so a forwarded write to x0 must never win.
         assign src_data[gi] = (i_byp_valid && (i_byp_rd == src_idx[gi]) &&
                                (src_idx[gi] != '0)) ? i_byp_data : src_raw[gi];
`else
         assign src_data[gi] = src_raw[gi];
`endif
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Decode of the incoming beat
   // -------------------------------------------------------------------------
   beat_t dec_beat;

   always_comb begin
      dec_beat         = BEAT_RESET;
      dec_beat.rd      = i_rd;
      case (i_opcode)
         OPC_OP: begin
            dec_beat.op1    = src_data[0];
            dec_beat.op2    = src_data[1];
            dec_beat.alu_op = funct_map(i_funct3, i_funct7_5, 1'b1);
         end
         OPC_OP_IMM: begin
            dec_beat.op1    = src_data[0];
            dec_beat.op2    = i_imm;
            dec_beat.alu_op = funct_map(i_funct3, i_funct7_5, 1'b0);
         end
         OPC_LUI: begin
            dec_beat.op2    = i_imm;
         end
         OPC_AUIPC: begin
            dec_beat.op1    = i_pc;
            dec_beat.op2    = i_imm;
         end
         default: begin
            // Unsupported opcodes still travel down the pipe so the exception
            // can be raised in order; operands stay zero and nothing writes back.
            dec_beat.illegal = 1'b1;
         end
      endcase
      dec_beat.wb_en = !dec_beat.illegal && (i_rd != '0);
   end

   // -------------------------------------------------------------------------
   // Output register + skid register
   // -------------------------------------------------------------------------
   logic  out_valid_reg, out_valid_next;
   logic  sk_valid_reg,  sk_valid_next;
   logic  ready_reg,     ready_next;
   beat_t out_beat_reg,  out_beat_next;
   beat_t sk_beat_reg,   sk_beat_next;
   logic  accept;
   logic  xfer;

   assign accept = i_valid & ready_reg;
   assign xfer   = out_valid_reg & i_ready;

   always_comb begin
      out_valid_next = out_valid_reg;
      sk_valid_next  = sk_valid_reg;
      out_beat_next  = out_beat_reg;
      sk_beat_next   = sk_beat_reg;

      if (i_flush) begin
         // Flush drops everything, including a beat offered this cycle.
         out_valid_next = 1'b0;
         sk_valid_next  = 1'b0;
      end else if (!out_valid_reg || xfer) begin
         // Output slot frees up this cycle. The skid entry is older than any
         // new beat, so it always moves forward first.
         if (sk_valid_reg) begin
            out_beat_next  = sk_beat_reg;
            out_valid_next = 1'b1;
            if (accept) begin
               sk_beat_next  = dec_beat;
               sk_valid_next = 1'b1;
            end else begin
               sk_valid_next = 1'b0;
            end
         end else if (accept) begin
            out_beat_next  = dec_beat;
            out_valid_next = 1'b1;
         end else begin
            out_valid_next = 1'b0;
         end
      end else if (accept) begin
         // Output is stalled: park the beat in the skid register.
         sk_beat_next  = dec_beat;
         sk_valid_next = 1'b1;
      end

      // o_ready is a pure flop: it reflects whether the skid slot will be free.
      ready_next = !sk_valid_next;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         out_valid_reg <= 1'b0;
         sk_valid_reg  <= 1'b0;
         ready_reg     <= 1'b1;
         out_beat_reg  <= BEAT_RESET;
         sk_beat_reg   <= BEAT_RESET;
      end else begin
         out_valid_reg <= out_valid_next;
         sk_valid_reg  <= sk_valid_next;
         ready_reg     <= ready_next;
         out_beat_reg  <= out_beat_next;
         sk_beat_reg   <= sk_beat_next;
      end
   end

   assign o_valid   = out_valid_reg;
   assign o_ready   = ready_reg;
   assign o_op1     = out_beat_reg.op1;
   assign o_op2     = out_beat_reg.op2;
   assign o_alu_op  = out_beat_reg.alu_op;
   assign o_rd      = out_beat_reg.rd;
   assign o_wb_en   = out_beat_reg.wb_en;
   assign o_illegal = out_beat_reg.illegal;

endmodule

// File: tb/tb_alu_operand_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_operand_stage
//
// Self-checking bench. The reference is a two-deep FIFO of expected beats:
// o_valid is "FIFO not empty", o_ready is "FIFO not full", and the output
// fields must equal the FIFO head. Each expected beat is computed from the
// instruction-field rules directly. Directed beats with literal expectations
// pin the model, then randomized traffic (valid, back-pressure, flush and one
// asynchronous reset) runs against it.
// -----------------------------------------------------------------------------

module tb_alu_operand_stage;
   import alu_operand_stage_pkg::*;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              flush = 1'b0;
   logic              valid = 1'b0;
   logic              ready_in = 1'b0;
   logic [6:0]        opcode = '0;
   logic [2:0]        funct3 = '0;
   logic              f75 = 1'b0;
   logic [XLEN-1:0]   rs1_data = '0;
   logic [XLEN-1:0]   rs2_data = '0;
   logic [XLEN-1:0]   imm = '0;
   logic [XLEN-1:0]   pc = '0;
   logic [REG_AW-1:0] rd = '0;
`ifdef ALU_OPSTAGE_BYPASS_EN
   logic              byp_valid = 1'b0;
   logic [REG_AW-1:0] byp_rd = '0;
   logic [XLEN-1:0]   byp_data = '0;
   logic [REG_AW-1:0] rs1 = '0;
   logic [REG_AW-1:0] rs2 = '0;
`endif

   logic              o_ready;
   logic              o_valid;
   logic [XLEN-1:0]   o_op1;
   logic [XLEN-1:0]   o_op2;
   alu_opcode_t       o_alu_op;
   logic [REG_AW-1:0] o_rd;
   logic              o_wb_en;
   logic              o_illegal;

   always #5 clk = ~clk;

   alu_operand_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_flush    (flush),
      .i_valid    (valid),
      .o_ready    (o_ready),
      .i_opcode   (opcode),
      .i_funct3   (funct3),
      .i_funct7_5 (f75),
      .i_rs1_data (rs1_data),
      .i_rs2_data (rs2_data),
      .i_imm      (imm),
      .i_pc       (pc),
      .i_rd       (rd),
`ifdef ALU_OPSTAGE_BYPASS_EN
      .i_byp_valid(byp_valid),
      .i_byp_rd   (byp_rd),
      .i_byp_data (byp_data),
      .i_rs1      (rs1),
      .i_rs2      (rs2),
`endif
      .o_valid    (o_valid),
      .i_ready    (ready_in),
      .o_op1      (o_op1),
      .o_op2      (o_op2),
      .o_alu_op   (o_alu_op),
      .o_rd       (o_rd),
      .o_wb_en    (o_wb_en),
      .o_illegal  (o_illegal)
   );

   typedef struct {
      logic [31:0] op1;
      logic [31:0] op2;
      logic [3:0]  alu_op;
      logic [4:0]  rd;
      logic        wb_en;
      logic        illegal;
   } exp_t;

   exp_t q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Instruction-field rules for OP / OP-IMM.
   function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt, input bit is_reg);
      case (f3)
         3'd0: return (is_reg && alt) ? 4'(ALU_SUB) : 4'(ALU_ADD);
         3'd1: return 4'(ALU_SLL);
         3'd2: return 4'(ALU_SLT);
         3'd3: return 4'(ALU_SLTU);
         3'd4: return 4'(ALU_XOR);
         3'd5: return alt ? 4'(ALU_SRA) : 4'(ALU_SRL);
         3'd6: return 4'(ALU_OR);
         default: return 4'(ALU_AND);
      endcase
   endfunction

   function automatic exp_t model_beat();
      exp_t        e;
      logic [31:0] a = rs1_data;
      logic [31:0] b = rs2_data;
`ifdef ALU_OPSTAGE_BYPASS_EN
      if (byp_valid && rs1 != 0 && byp_rd == rs1) a = byp_data;
      if (byp_valid && rs2 != 0 && byp_rd == rs2) b = byp_data;
`endif
      e.op1 = 0; e.op2 = 0; e.alu_op = 4'(ALU_ADD); e.rd = rd; e.illegal = 1'b0;
      if (opcode == 7'h33) begin
         e.op1 = a; e.op2 = b; e.alu_op = arith_op(funct3, f75, 1'b1);
      end else if (opcode == 7'h13) begin
         e.op1 = a; e.op2 = imm; e.alu_op = arith_op(funct3, f75, 1'b0);
      end else if (opcode == 7'h37) begin
         e.op2 = imm;
      end else if (opcode == 7'h17) begin
         e.op1 = pc; e.op2 = imm;
      end else begin
         e.illegal = 1'b1;
      end
      e.wb_en = !e.illegal && (rd != 0);
      return e;
   endfunction

   // Per-cycle comparison of the DUT against the FIFO model.
   task automatic compare_all();
      chk("o_valid", 32'(o_valid), (q.size() > 0) ? 32'd1 : 32'd0);
      chk("o_ready", 32'(o_ready), (q.size() < 2) ? 32'd1 : 32'd0);
      if (q.size() > 0) begin
         chk("o_op1",     o_op1,            q[0].op1);
         chk("o_op2",     o_op2,            q[0].op2);
         chk("o_alu_op",  32'(o_alu_op),    32'(q[0].alu_op));
         chk("o_rd",      32'(o_rd),        32'(q[0].rd));
         chk("o_wb_en",   32'(o_wb_en),     32'(q[0].wb_en));
         chk("o_illegal", 32'(o_illegal),   32'(q[0].illegal));
      end
   endtask

   // Called just after a falling edge with inputs already driven: advance the
   // model for the coming rising edge, then compare after it.
   task automatic step();
      bit acc;
      bit xf;
      acc = valid && (q.size() < 2) && !flush;
      xf  = (q.size() > 0) && ready_in;
      if (flush) begin
         q.delete();
      end else begin
         if (xf)  q.delete(0);
         if (acc) q.push_back(model_beat());
      end
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, ".o_valid"},   32'(o_valid),   32'd0);
      chk({tag, ".o_ready"},   32'(o_ready),   32'd1);
      chk({tag, ".o_op1"},     o_op1,          32'd0);
      chk({tag, ".o_op2"},     o_op2,          32'd0);
      chk({tag, ".o_alu_op"},  32'(o_alu_op),  32'(ALU_ADD));
      chk({tag, ".o_rd"},      32'(o_rd),      32'd0);
      chk({tag, ".o_wb_en"},   32'(o_wb_en),   32'd0);
      chk({tag, ".o_illegal"}, 32'(o_illegal), 32'd0);
   endtask

   task automatic set_beat(input logic [6:0] opc, input logic [2:0] f3, input logic alt,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] immv,
                           input logic [31:0] pcv, input logic [4:0] rdv);
      valid = 1'b1; opcode = opc; funct3 = f3; f75 = alt;
      rs1_data = a; rs2_data = b; imm = immv; pc = pcv; rd = rdv;
   endtask

   task automatic rand_inputs(input int p_valid, input int p_ready, input int p_flush);
      valid    = ($urandom_range(0, 99) < p_valid);
      ready_in = ($urandom_range(0, 99) < p_ready);
      flush    = ($urandom_range(0, 99) < p_flush);
      case ($urandom_range(0, 4))
         0: opcode = 7'h33;
         1: opcode = 7'h13;
         2: opcode = 7'h37;
         3: opcode = 7'h17;
         default: opcode = 7'($urandom());
      endcase
      funct3   = 3'($urandom());
      f75      = 1'($urandom());
      rs1_data = $urandom();
      rs2_data = $urandom();
      imm      = $urandom();
      pc       = $urandom();
      rd       = 5'($urandom_range(0, 31));
`ifdef ALU_OPSTAGE_BYPASS_EN
      byp_valid = 1'($urandom());
      byp_rd    = 5'($urandom_range(0, 3));
      byp_data  = $urandom();
      rs1       = 5'($urandom_range(0, 3));
      rs2       = 5'($urandom_range(0, 3));
`endif
   endtask

   initial begin
      // ---------------- reset ----------------
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst_n = 1'b1;
      @(negedge clk);
      compare_all();

      // ---------------- directed decode ----------------
      ready_in = 1'b1;
      set_beat(7'h33, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 32'd0, 5'd1);
      step();
      chk("add.o_valid",  32'(o_valid),  32'd1);
      chk("add.o_op1",    o_op1,         32'd5);
      chk("add.o_op2",    o_op2,         32'd7);
      chk("add.o_alu_op", 32'(o_alu_op), 32'(ALU_ADD));
      chk("add.o_wb_en",  32'(o_wb_en),  32'd1);

      set_beat(7'h13, 3'd5, 1'b1, 32'h8000_0000, 32'd0, 32'd4, 32'd0, 5'd2);
      step();
      chk("srai.o_alu_op", 32'(o_alu_op), 32'(ALU_SRA));
      chk("srai.o_op1",    o_op1,         32'h8000_0000);
      chk("srai.o_op2",    o_op2,         32'd4);

      set_beat(7'h17, 3'd0, 1'b0, 32'hAAAA, 32'hBBBB, 32'h1000, 32'h100, 5'd3);
      step();
      chk("auipc.o_op1", o_op1, 32'h100);
      chk("auipc.o_op2", o_op2, 32'h1000);

      set_beat(7'h03, 3'd2, 1'b0, 32'h1234, 32'h5678, 32'h10, 32'h0, 5'd4);
      step();
      chk("load.o_illegal", 32'(o_illegal), 32'd1);
      chk("load.o_wb_en",   32'(o_wb_en),   32'd0);
      chk("load.o_op1",     o_op1,          32'd0);

      set_beat(7'h33, 3'd0, 1'b1, 32'd9, 32'd2, 32'd0, 32'd0, 5'd0);
      step();
      chk("rd0.o_alu_op", 32'(o_alu_op), 32'(ALU_SUB));
      chk("rd0.o_wb_en",  32'(o_wb_en),  32'd0);

      valid = 1'b0;
      step();

      // ---------------- back-pressure ----------------
      ready_in = 1'b0;
      set_beat(7'h33, 3'd4, 1'b0, 32'd1, 32'd1, 32'd0, 32'd0, 5'd11);
      step();
      set_beat(7'h33, 3'd6, 1'b0, 32'd2, 32'd2, 32'd0, 32'd0, 5'd12);
      step();
      chk("bp.full.o_ready", 32'(o_ready), 32'd0);
      chk("bp.full.o_rd",    32'(o_rd),    32'd11);
      set_beat(7'h33, 3'd7, 1'b0, 32'd3, 32'd3, 32'd0, 32'd0, 5'd13);
      step();
      chk("bp.stall.o_ready", 32'(o_ready), 32'd0);
      chk("bp.stall.o_rd",    32'(o_rd),    32'd11);
      ready_in = 1'b1;
      step();
      chk("bp.drain1.o_rd",    32'(o_rd),    32'd12);
      chk("bp.drain1.o_ready", 32'(o_ready), 32'd1);
      step();
      chk("bp.drain2.o_rd", 32'(o_rd), 32'd13);
      valid = 1'b0;
      step();
      chk("bp.empty.o_valid", 32'(o_valid), 32'd0);

      // ---------------- flush with full stage ----------------
      ready_in = 1'b0;
      set_beat(7'h13, 3'd0, 1'b0, 32'd21, 32'd0, 32'd1, 32'd0, 5'd21);
      step();
      set_beat(7'h13, 3'd0, 1'b0, 32'd22, 32'd0, 32'd1, 32'd0, 5'd22);
      step();
      set_beat(7'h13, 3'd0, 1'b0, 32'd23, 32'd0, 32'd1, 32'd0, 5'd23);
      flush = 1'b1;
      step();
      chk("flush.o_valid", 32'(o_valid), 32'd0);
      chk("flush.o_ready", 32'(o_ready), 32'd1);
      flush = 1'b0; valid = 1'b0; ready_in = 1'b1;
      step();
      chk("flush.after.o_valid", 32'(o_valid), 32'd0);

`ifdef ALU_OPSTAGE_BYPASS_EN
      // ---------------- forwarding ----------------
      set_beat(7'h33, 3'd0, 1'b0, 32'h1111, 32'h2222, 32'd0, 32'd0, 5'd5);
      rs1 = 5'd3; rs2 = 5'd4; byp_valid = 1'b1; byp_rd = 5'd3; byp_data = 32'hDEAD;
      step();
      chk("byp.o_op1", o_op1, 32'hDEAD);
      chk("byp.o_op2", o_op2, 32'h2222);
      rs1 = 5'd0; byp_rd = 5'd0;
      step();
      chk("byp.x0.o_op1", o_op1, 32'h1111);
      valid = 1'b0; byp_valid = 1'b0;
      step();
`endif

      // ---------------- randomized traffic ----------------
      for (int i = 0; i < 1500; i++) begin
         rand_inputs(70, 60, 3);
         step();
      end

      // ---------------- asynchronous reset mid-stream ----------------
      ready_in = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rand_inputs(100, 0, 0);
         step();
      end
      #2 rst_n = 1'b0;
      #1 check_reset_values("areset");
      q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 1500; i++) begin
         rand_inputs(60, 50, 2);
         step();
      end

      valid = 1'b0; flush = 1'b0; ready_in = 1'b1;
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
